// File: rtl/tl45_pfetch_cache_dm.sv
// tl45_pfetch_cache_dm: direct-mapped instruction prefetch cache for the tl45 fetch stage.
// A hit delivers one instruction per cycle to decode. A miss refills the whole line with a
// pipelined Wishbone burst: strobes are issued back to back and acks are counted.
// Defining TL45_PFETCH_PERF_EN adds saturating hit/miss counters (o_hit_cnt, o_miss_cnt).
module tl45_pfetch_cache_dm #(
  parameter int          LINE_WORDS = 16,
  parameter int          NUM_LINES  = 256,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  input  logic        i_new_pc,
  input  logic [31:0] i_pc,
  input  logic        i_cache_inv,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [29:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_buf_pc,
  output logic [31:0] o_buf_inst,
  output logic        o_cache_hit,
`ifdef TL45_PFETCH_PERF_EN
  output logic [31:0] o_hit_cnt,
  output logic [31:0] o_miss_cnt,
`endif
  output logic        o_bus_err
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t                   state_q, state_d;
  logic [31:0]              pc_q;
  logic [31:0]              buf_pc_q, buf_inst_q;
  logic                     cyc_q, stb_q, bus_err_q, inv_pend_q;
  logic [29:0]              addr_q;
  logic [OFF_W-1:0]         req_cnt_q, ack_cnt_q;
  logic [IDX_W-1:0]         fill_idx_q;
  logic [NUM_LINES-1:0]     valid_q;
  logic [TAG_W-1:0]         tags_q [NUM_LINES];
  logic [31:0]              data_q [NUM_LINES*LINE_WORDS];

  logic [OFF_W-1:0]         pc_off;
  logic [IDX_W-1:0]         pc_idx;
  logic [TAG_W-1:0]         pc_tag;
  logic [IDX_W+OFF_W-1:0]   rd_addr, wr_addr;
  logic                     hit, start_fill, ack_ok, last_ack, fill_err, req_accept;

  assign pc_off  = pc_q[OFF_W-1:0];
  assign pc_idx  = pc_q[OFF_W+IDX_W-1:OFF_W];
  assign pc_tag  = pc_q[31:OFF_W+IDX_W];
  assign rd_addr = {pc_idx, pc_off};
  assign wr_addr = {fill_idx_q, ack_cnt_q};

  // Hit only counts while no refill is in flight, so a half-written line is never read.
  assign hit        = (state_q == S_IDLE) && valid_q[pc_idx] && (tags_q[pc_idx] == pc_tag);
  assign req_accept = stb_q && !i_wb_stall;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state plus the fill events the datapath reacts to; err takes precedence over ack.
  always_comb begin
    state_d    = state_q;
    start_fill = 1'b0;
    ack_ok     = 1'b0;
    last_ack   = 1'b0;
    fill_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!hit) begin
          start_fill = 1'b1;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (i_wb_err) begin
          fill_err = 1'b1;
          state_d  = S_IDLE;
        end else if (i_wb_ack) begin
          ack_ok = 1'b1;
          if (ack_cnt_q == LAST_WORD) begin
            last_ack = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Burst master: sequential requests from the line base, acks counted into the latched line.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      addr_q     <= '0;
      req_cnt_q  <= '0;
      ack_cnt_q  <= '0;
      fill_idx_q <= '0;
      bus_err_q  <= 1'b0;
      inv_pend_q <= 1'b0;
    end else begin
      bus_err_q <= fill_err;
      if (start_fill) begin
        addr_q     <= {pc_q[29:OFF_W], {OFF_W{1'b0}}};
        cyc_q      <= 1'b1;
        stb_q      <= 1'b1;
        req_cnt_q  <= '0;
        ack_cnt_q  <= '0;
        fill_idx_q <= pc_idx;
        inv_pend_q <= 1'b0;
      end else begin
        if (req_accept) begin
          addr_q    <= addr_q + 30'd1;
          req_cnt_q <= req_cnt_q + 1'b1;
          if (req_cnt_q == LAST_WORD) stb_q <= 1'b0;
        end
        if (ack_ok) ack_cnt_q <= ack_cnt_q + 1'b1;
        if (last_ack || fill_err) begin
          cyc_q <= 1'b0;
          stb_q <= 1'b0;
        end
        // An invalidate seen at any point of the burst keeps that line from going valid.
        if (state_q == S_FILL && i_cache_inv) inv_pend_q <= 1'b1;
      end
    end
  end

  // Valid bits: invalidate beats everything, a new fill kills its line until the last ack.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                              valid_q <= '0;
    else if (i_cache_inv)                     valid_q <= '0;
    else if (start_fill)                      valid_q[pc_idx] <= 1'b0;
    else if (last_ack && !inv_pend_q)         valid_q[fill_idx_q] <= 1'b1;
  end

  // Tag and data storage, left unreset so it maps onto RAM.
  always_ff @(posedge i_clk) begin
    if (start_fill) tags_q[pc_idx] <= pc_tag;
    if (ack_ok)     data_q[wr_addr] <= i_wb_data;
  end

  // Decode-facing registers and PC: flush/new_pc, then stall, then hit delivery.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_q       <= RESET_PC;
      buf_pc_q   <= '0;
      buf_inst_q <= '0;
    end else if (i_pipe_flush || i_new_pc) begin
      buf_pc_q   <= '0;
      buf_inst_q <= '0;
      if (i_new_pc) pc_q <= i_pc;
    end else if (!i_pipe_stall) begin
      if (hit) begin
        buf_inst_q <= data_q[rd_addr];
        buf_pc_q   <= pc_q;
        pc_q       <= pc_q + 32'd1;
      end else begin
        buf_pc_q   <= '0;
        buf_inst_q <= '0;
      end
    end
  end

`ifdef TL45_PFETCH_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        deliver;
  assign deliver = hit && !i_pipe_flush && !i_new_pc && !i_pipe_stall;

  // Saturating counters of delivered hits and started refills.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (deliver && hit_cnt_q != 32'hFFFF_FFFF)     hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (start_fill && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign o_hit_cnt  = hit_cnt_q;
  assign o_miss_cnt = miss_cnt_q;
`endif

  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = 1'b0;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = 32'h0;
  assign o_wb_sel    = 4'hF;
  assign o_buf_pc    = buf_pc_q;
  assign o_buf_inst  = buf_inst_q;
  assign o_cache_hit = hit;
  assign o_bus_err   = bus_err_q;

endmodule

// File: tb/tb_tl45_pfetch_cache_dm.sv
// Bench for tl45_pfetch_cache_dm: zero-wait pipelined Wishbone slave whose data is a fixed
// function of the word address, a table of per-cycle decode vectors, hand sequences for the
// multi-cycle cases, and a randomized phase checked against a PC/memory scoreboard.
`timescale 1ns/1ps
module tb_tl45_pfetch_cache_dm;
  localparam int LW = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_stall, pipe_flush, new_pc, cache_inv;
  logic [31:0] pc_in;
  logic        wb_cyc, wb_stb, wb_we;
  logic [29:0] wb_addr;
  logic [31:0] wb_dout;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_stall, wb_err;
  logic [31:0] wb_din;
  logic [31:0] buf_pc, buf_inst;
  logic        cache_hit, bus_err;
`ifdef TL45_PFETCH_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  tl45_pfetch_cache_dm #(.LINE_WORDS(LW), .NUM_LINES(256), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_reset(rst), .i_pipe_stall(pipe_stall), .i_pipe_flush(pipe_flush),
    .i_new_pc(new_pc), .i_pc(pc_in), .i_cache_inv(cache_inv),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_dout), .o_wb_sel(wb_sel), .i_wb_ack(wb_ack), .i_wb_stall(wb_stall),
    .i_wb_err(wb_err), .i_wb_data(wb_din), .o_buf_pc(buf_pc), .o_buf_inst(buf_inst),
    .o_cache_hit(cache_hit),
`ifdef TL45_PFETCH_PERF_EN
    .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt),
`endif
    .o_bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] key = 32'h0;

  int          err_after = -1;
  int          stall_force = 0;
  bit          rand_stall = 1'b0;
  bit          inv_on_last = 1'b0;
  bit          inv_req = 1'b0;
  logic [29:0] reqs[$];
  logic [29:0] stall_addrs[$];

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {2'b00, a} ^ key;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_hit(input string name, input int maxc);
    int n = 0;
    while (!cache_hit && n < maxc) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!cache_hit) begin
      miscompares++;
      $display("FAIL %s: no hit within %0d cycles", name, maxc);
    end
  endtask

  task automatic check_burst(input string name, input logic [29:0] base);
    int bad = 0;
    int n = reqs.size();
    if (n < LW) bad = LW;
    else for (int i = 0; i < LW; i++) if (reqs[n-LW+i] !== base + 30'(i)) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  task automatic jump(input logic [31:0] target);
    new_pc = 1'b1;
    pc_in  = target;
    @(negedge clk);
    new_pc = 1'b0;
  endtask

  // Zero-wait pipelined slave: a request accepted at one edge is acked at the next.
  initial begin : slave
    bit          pend_v = 1'b0;
    logic [29:0] pend_a = '0;
    bit          in_burst = 1'b0;
    logic [29:0] last_req = '0;
    int          burst_acks = 0;
    wb_ack = 0; wb_err = 0; wb_stall = 0; wb_din = 0; cache_inv = 0;
    forever begin
      @(negedge clk);
      wb_ack = 1'b0; wb_err = 1'b0; cache_inv = 1'b0;
      if (!wb_cyc || rst) begin
        burst_acks = 0;
        in_burst   = 1'b0;
      end
      if (pend_v && wb_cyc && !rst) begin
        if (err_after == 0) begin
          wb_err    = 1'b1;
          err_after = -1;
        end else begin
          wb_ack = 1'b1;
          wb_din = mem_word(pend_a);
          burst_acks++;
          if (err_after > 0) err_after--;
          if (inv_on_last && burst_acks == LW) begin
            cache_inv   = 1'b1;
            inv_on_last = 1'b0;
          end
        end
      end
      if (inv_req) begin
        cache_inv = 1'b1;
        inv_req   = 1'b0;
      end
      pend_v = 1'b0;
      if (stall_force > 0) begin
        wb_stall = 1'b1;
        stall_force--;
      end else begin
        wb_stall = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      if (wb_cyc && wb_stb && wb_stall) stall_addrs.push_back(wb_addr);
      if (wb_cyc && wb_stb && !wb_stall) begin
        if (!in_burst) check("burst_start_aligned", {28'b0, wb_addr[3:0]}, 32'd0);
        else           check("burst_addr_step", {2'b0, wb_addr}, {2'b0, last_req + 30'd1});
        in_burst = 1'b1;
        last_req = wb_addr;
        pend_v   = 1'b1;
        pend_a   = wb_addr;
        reqs.push_back(wb_addr);
      end
    end
  end

  typedef struct {
    bit          np;
    logic [31:0] pc;
    bit          fl;
    bit          st;
    bit          ehit;
    logic [31:0] epc;
    bit          bub;
  } vec_t;

  function automatic vec_t mk(bit np, logic [31:0] pc, bit fl, bit st, bit ehit,
                              logic [31:0] epc, bit bub);
    vec_t v;
    v.np = np; v.pc = pc; v.fl = fl; v.st = st; v.ehit = ehit; v.epc = epc; v.bub = bub;
    return v;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = 32'($urandom_range(0, 32'h17F));
    if ($urandom_range(0, 3) == 0) p = p | 32'h1000;
    return p;
  endfunction

  initial begin : main
    vec_t        tbl[18];
    int          n;
    int          mark;
    int          bad;
    int          deliveries;
    logic [31:0] exp_next, last_pc, last_inst, ap_pc;
    bit          ap_np, ap_fl, ap_st, hit_before;

    tbl[0]  = mk(0, 0,  0, 0, 1, 0,  0);
    tbl[1]  = mk(0, 0,  0, 0, 1, 1,  0);
    tbl[2]  = mk(0, 0,  0, 0, 1, 2,  0);
    tbl[3]  = mk(0, 0,  0, 1, 1, 2,  0);
    tbl[4]  = mk(0, 0,  0, 1, 1, 2,  0);
    tbl[5]  = mk(0, 0,  0, 1, 1, 2,  0);
    tbl[6]  = mk(0, 0,  0, 1, 1, 2,  0);
    tbl[7]  = mk(0, 0,  0, 0, 1, 3,  0);
    tbl[8]  = mk(0, 0,  1, 0, 1, 0,  1);
    tbl[9]  = mk(0, 0,  0, 0, 1, 4,  0);
    tbl[10] = mk(1, 1,  0, 0, 1, 0,  1);
    tbl[11] = mk(0, 0,  0, 0, 1, 1,  0);
    tbl[12] = mk(0, 0,  1, 1, 1, 0,  1);
    tbl[13] = mk(0, 0,  0, 0, 1, 2,  0);
    tbl[14] = mk(1, 14, 0, 0, 1, 0,  1);
    tbl[15] = mk(0, 0,  0, 0, 1, 14, 0);
    tbl[16] = mk(0, 0,  0, 0, 1, 15, 0);
    tbl[17] = mk(0, 0,  0, 0, 0, 0,  1);

    rst = 1'b1; pipe_stall = 0; pipe_flush = 0; new_pc = 0; pc_in = 0;
    repeat (3) @(negedge clk);
    check("rst_buf_pc", buf_pc, 32'h0);
    check("rst_buf_inst", buf_inst, 32'h0);
    check("rst_cyc", {31'b0, wb_cyc}, 32'h0);
    check("rst_stb", {31'b0, wb_stb}, 32'h0);
    check("rst_bus_err", {31'b0, bus_err}, 32'h0);
    check("rst_hit", {31'b0, cache_hit}, 32'h0);
    check("const_we_sel_data", {wb_dout[27:0], wb_sel}, {28'h0, 4'hF});
    check("const_we", {31'b0, wb_we}, 32'h0);

    // First fill after reset: 16 strobes at 0..15, first hit LW+2 cycles after release.
    rst = 1'b0;
    n = 0;
    while (!cache_hit && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("first_hit_latency", 32'(n), 32'(LW + 2));
    check("first_burst_len", 32'(reqs.size()), 32'd16);
    check_burst("first_burst_addrs", 30'h0);

    // Per-cycle decode vectors on line 0: sequential hits, stall hold, flush, new_pc.
    for (int i = 0; i < 18; i++) begin
      new_pc = tbl[i].np; pc_in = tbl[i].pc; pipe_flush = tbl[i].fl; pipe_stall = tbl[i].st;
      check($sformatf("vec%0d_hit", i), {31'b0, cache_hit}, {31'b0, tbl[i].ehit});
      @(negedge clk);
      check($sformatf("vec%0d_pc", i), buf_pc, tbl[i].bub ? 32'h0 : tbl[i].epc);
      check($sformatf("vec%0d_inst", i), buf_inst,
            tbl[i].bub ? 32'h0 : mem_word(tbl[i].epc[29:0]));
    end
    new_pc = 0; pipe_flush = 0; pipe_stall = 0;

    // new_pc during the line-1 fill; 0x20 then refills line 2; 0x2 hits with no bus traffic.
    jump(32'h20);
    check("np20_bubble", buf_pc | buf_inst, 32'h0);
    wait_hit("np20_hit", 200);
    check("np20_total_reqs", 32'(reqs.size()), 32'd48);
    check_burst("np20_burst", 30'h20);
    jump(32'h2);
    check("np2_bubble", buf_pc | buf_inst, 32'h0);
    check("np2_hit", {31'b0, cache_hit}, 32'd1);
    @(negedge clk);
    check("np2_pc", buf_pc, 32'h2);
    check("np2_inst", buf_inst, mem_word(30'h2));
    check("np2_no_bus", 32'(reqs.size()), 32'd48);
    check("np2_cyc_idle", {31'b0, wb_cyc}, 32'd0);

    // Aliasing: 0x1000 shares index 0 with 0x0 under a different tag.
    jump(32'h1000);
    check("alias_miss", {31'b0, cache_hit}, 32'd0);
    wait_hit("alias_hit", 100);
    check_burst("alias_burst", 30'h1000);
    @(negedge clk);
    check("alias_pc", buf_pc, 32'h1000);
    check("alias_inst", buf_inst, mem_word(30'h1000));
    jump(32'h0);
    check("return0_miss", {31'b0, cache_hit}, 32'd0);
    wait_hit("return0_hit", 100);
    check("return0_total_reqs", 32'(reqs.size()), 32'd80);
    check_burst("return0_burst", 30'h0);
    @(negedge clk);
    @(negedge clk);
    check("return0_pc1", buf_pc, 32'h1);

    // Bus error on the 5th ack of the 0x300 fill.
    err_after = 4;
    jump(32'h300);
    mark = reqs.size();
    n = 0;
    while (!bus_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("err_pulse", {31'b0, bus_err}, 32'd1);
    check("err_cyc_dropped", {31'b0, wb_cyc}, 32'd0);
    check("err_no_hit", {31'b0, cache_hit}, 32'd0);
    @(negedge clk);
    check("err_pulse_single", {31'b0, bus_err}, 32'd0);
    check("err_restart_cyc", {31'b0, wb_cyc}, 32'd1);
    check("err_restart_addr", {2'b0, wb_addr}, 32'h300);
    wait_hit("err_refill_hit", 100);
    check("err_total_reqs", 32'(reqs.size() - mark), 32'd22);
    check_burst("err_refill_burst", 30'h300);
    @(negedge clk);
    check("err_refill_inst", buf_inst, mem_word(30'h300));

    // Three wb_stall cycles in the middle of the 0x400 burst.
    stall_addrs.delete();
    jump(32'h400);
    mark = reqs.size();
    n = 0;
    while (reqs.size() - mark < 5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    stall_force = 3;
    wait_hit("stall_hit", 100);
    check("stall_req_count", 32'(reqs.size() - mark), 32'd16);
    check_burst("stall_burst", 30'h400);
    check("stall_cycles_seen", 32'(stall_addrs.size()), 32'd3);
    bad = 0;
    foreach (stall_addrs[i]) if (stall_addrs[i] !== stall_addrs[0]) bad++;
    check("stall_addr_held", 32'(bad), 32'd0);
    @(negedge clk);
    check("stall_line_inst", buf_inst, mem_word(30'h400));

    // Invalidate on the same cycle as the last ack of the 0x500 fill.
    jump(32'h500);
    mark = reqs.size();
    inv_on_last = 1'b1;
    wait_hit("inv_refetch_hit", 200);
    check("inv_refetch_reqs", 32'(reqs.size() - mark), 32'd32);
    check_burst("inv_refetch_burst", 30'h500);
    jump(32'h400);
    check("inv_cleared_other_line", {31'b0, cache_hit}, 32'd0);
    wait_hit("inv_other_refill", 100);

    // Randomized phase: new memory contents, random control and slave stalls.
    pipe_stall = 1'b1;
    key = 32'hC0DE_0000;
    inv_req = 1'b1;
    repeat (3) @(negedge clk);
    pipe_stall = 1'b0;
    rand_stall = 1'b1;
    exp_next = 0; last_pc = buf_pc; last_inst = buf_inst; deliveries = 0;
    for (int c = 0; c < 3000; c++) begin
      ap_np = (c == 0) || ($urandom_range(0, 15) == 0);
      ap_pc = rand_pc();
      ap_fl = ($urandom_range(0, 15) == 0);
      ap_st = ($urandom_range(0, 7) == 0);
      new_pc = ap_np; pc_in = ap_pc; pipe_flush = ap_fl; pipe_stall = ap_st;
      hit_before = cache_hit;
      check("rnd_hit_only_idle", {31'b0, cache_hit & wb_cyc}, 32'd0);
      @(negedge clk);
      if (ap_np || ap_fl) begin
        check("rnd_bubble_pc", buf_pc, 32'h0);
        check("rnd_bubble_inst", buf_inst, 32'h0);
      end else if (ap_st) begin
        check("rnd_stall_pc", buf_pc, last_pc);
        check("rnd_stall_inst", buf_inst, last_inst);
      end else if (hit_before) begin
        check("rnd_deliver_pc", buf_pc, exp_next);
        check("rnd_deliver_inst", buf_inst, mem_word(exp_next[29:0]));
        exp_next = exp_next + 32'd1;
        deliveries++;
      end else begin
        check("rnd_miss_pc", buf_pc, 32'h0);
        check("rnd_miss_inst", buf_inst, 32'h0);
      end
      if (ap_np) exp_next = ap_pc;
      last_pc = buf_pc;
      last_inst = buf_inst;
    end
    new_pc = 0; pipe_flush = 0; pipe_stall = 0; rand_stall = 1'b0;
    check("rnd_enough_deliveries", 32'(deliveries > 300), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tl45_pfetch_cache_dm.md
Name: tl45_pfetch_cache_dm

Overview:
- Parametrised direct-mapped instruction prefetch cache; next generation of the tl45 fetch stage.
- Supplies one instruction per cycle to decode on a hit and refills a whole line on a miss using a pipelined Wishbone burst (back-to-back strobes, acks counted).
- Adds full-width tag compare, global invalidate, a bus-error report and configurable geometry.

Parameters:
- LINE_WORDS, 16, 32-bit words per line; power of 2, >=2; OFF_W = log2(LINE_WORDS).
- NUM_LINES, 256, lines in cache; power of 2, >=2; IDX_W = log2(NUM_LINES).
- RESET_PC, 32'h0, word address loaded into PC on reset.
- Derived: TAG_W = 32 - IDX_W - OFF_W.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-high reset
- i_pipe_stall  in  1  decode not accepting; hold outputs and PC
- i_pipe_flush  in  1  emit bubble next cycle, PC unchanged
- i_new_pc  in  1  load i_pc and emit bubble
- i_pc  in  32  new word-address PC
- i_cache_inv  in  1  clear all valid bits
- o_wb_cyc, o_wb_stb  out  1 each  Wishbone pipelined master controls
- o_wb_we  out  1  constant 0
- o_wb_addr  out  30  word address
- o_wb_data  out  32  constant 0
- o_wb_sel  out  4  constant 4'hF
- i_wb_ack, i_wb_stall, i_wb_err  in  1 each  Wishbone responses
- i_wb_data  in  32  read data
- o_buf_pc  out  32  PC of o_buf_inst; 0 = bubble
- o_buf_inst  out  32  instruction; 0 = bubble
- o_cache_hit  out  1  combinational hit for the current PC
- o_bus_err  out  1  one-cycle pulse on aborted fill

Behaviour:
- PC is a word address. Fields: offset = pc[OFF_W-1:0], index = pc[OFF_W+IDX_W-1:OFF_W], tag = pc[31:OFF_W+IDX_W].
- hit = valid[index] && tags[index]==tag && state==IDLE.
- Reset (async): state=IDLE, PC=RESET_PC, o_buf_pc=0, o_buf_inst=0, cyc=stb=0, o_bus_err=0, all valid=0, counters=0.
- Output register priority: reset > (flush|new_pc) > stall > normal.
  - flush|new_pc: outputs=0; if new_pc, PC<=i_pc.
  - stall: outputs and PC hold.
  - normal on hit: o_buf_inst<=data[index][offset], o_buf_pc<=PC, PC<=PC+1 (32-bit wrap). Otherwise outputs=0.
  - Hit latency: 1 cycle, one instruction per cycle sustained.
- FSM IDLE -> FILL: taken when !hit. Actions:
  - o_wb_addr <= {pc[29:OFF_W], 0}; tags[index] <= tag; valid[index] <= 0.
  - req_cnt=0, ack_cnt=0; cyc=1, stb=1.
  - Latch fill index for the whole burst.
- FILL request side: when stb && !i_wb_stall, o_wb_addr++ and req_cnt++. stb drops after LINE_WORDS requests are accepted. cyc stays high.
- FILL ack side: each ack without err writes data[fill_index][ack_cnt] <= i_wb_data and increments ack_cnt.
  - Last ack (ack_cnt==LINE_WORDS-1): valid[fill_index]<=1, cyc=stb=0, state=IDLE. The hit can occur on the next cycle.
  - Miss-to-first-instruction latency with zero-wait slave: LINE_WORDS+2 cycles.
- FILL on i_wb_err: cyc=stb=0 next cycle, valid stays 0, o_bus_err=1 for one cycle, state=IDLE. The miss re-fetches automatically.
- new_pc/flush during FILL: burst runs to completion (no cyc abandonment); PC updates per priority. The hit is re-evaluated on the new PC in IDLE.
- i_cache_inv clears every valid bit in one cycle. It wins over a same-cycle valid set at the end of a fill. During FILL it also suppresses the final valid set of that burst.
- Acks arriving while state==IDLE are ignored. ack and err are never counted beyond LINE_WORDS.
- Storage: tags and data arrays have no reset (inferred RAM); valid is a flop vector.

Optional Feature:
- Macro: TL45_PFETCH_PERF_EN.
- Defined: add outputs o_hit_cnt[31:0] and o_miss_cnt[31:0].
  - o_hit_cnt increments on each instruction delivered by a hit.
  - o_miss_cnt increments on each IDLE->FILL transition.
  - Both saturate at 32'hFFFFFFFF and are async reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, zero-wait slave returning data=addr: first fill issues 16 strobes at addr 0..15. o_buf_pc/o_buf_inst then read 0/0, 1/1, 2/2 … on consecutive cycles; PC 16 misses.
- i_new_pc with i_pc=0x20 after line 0 is filled, then i_new_pc with i_pc=0x2: 0x20 triggers a fill. 0x2 then hits with no bus activity and delivers 0x2 one cycle later.
- Aliasing: fill PC 0x0, then jump to PC 0x1000 (same index, different tag) -> miss and refill. Return to 0x0 -> miss again.
- i_wb_err on the 5th ack: o_bus_err pulses once, cyc drops next cycle, o_cache_hit stays 0, and a new 16-word burst restarts from the line base.
- i_wb_stall high for 3 cycles mid-burst: o_wb_addr holds and no requests are lost or duplicated. Exactly 16 acks complete the line.
- i_cache_inv on the same cycle as the last ack: line remains invalid and is re-fetched. i_pipe_stall held 4 cycles on hits: o_buf_* and PC frozen.
